// File: rtl/smem_output_writer.sv
// rtl/smem_output_writer.sv - result-line sink: FIFO buffering, host cache-line writes, status line
module smem_output_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int SLACK      = 4,
  parameter int CL_ADDR_W  = 58
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 start,
  input  logic [CL_ADDR_W-1:0] base_addr,
  input  logic                 output_request,
  output logic                 output_permit,
  input  logic [511:0]         output_data,
  input  logic                 output_valid,
  input  logic                 output_finish,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [CL_ADDR_W-1:0] wr_addr,
  output logic [511:0]         wr_data,
  input  logic                 wr_rsp_valid,
  output logic [31:0]          lines_written,
  output logic                 done,
  output logic                 error
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, GRANT, DRAIN, STATUS, WAIT_ACK, DONE} state_t;
  state_t state, state_nxt;

  logic [511:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CL_ADDR_W-1:0] base_q;
  logic [31:0]          lines_q;
  logic [31:0]          rsp_count;
  logic [1:0]           drain_cnt;
  logic                 error_q;
  logic                 permit_nxt;

  logic data_phase, fifo_empty, fifo_full, beat, push, pop, drop, arm;

  assign data_phase = (state == GRANT) || (state == DRAIN);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign beat       = data_phase && output_valid && !stall;
  assign pop        = data_phase && !fifo_empty && wr_ready;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign push       = beat && (!fifo_full || pop);
  assign drop       = beat && fifo_full && !pop;
  assign arm        = start && ((state == IDLE) || (state == DONE));

  assign lines_written = lines_q;
  assign done          = (state == DONE);
  assign error         = error_q;

  always_comb begin
    state_nxt  = state;
    permit_nxt = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = GRANT;
      end
      GRANT: begin
        if (output_finish && !stall) state_nxt = DRAIN;
        else permit_nxt = output_request && (count <= CNT_W'(FIFO_DEPTH - SLACK));
      end
      DRAIN: begin
        // Hold off long enough for beats still in the upstream valid pipeline.
        if (fifo_empty && !beat && (drain_cnt == 2'd3)) state_nxt = STATUS;
      end
      STATUS: begin
        wr_valid = 1'b1;
        wr_addr  = base_q;
        wr_data  = {480'b0, lines_q};
        if (wr_ready) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (rsp_count + 32'(wr_rsp_valid) == lines_q + 32'd1) state_nxt = DONE;
      end
      DONE: begin
        if (start) state_nxt = GRANT;
      end
      default: state_nxt = IDLE;
    endcase
    if (data_phase && !fifo_empty) begin
      wr_valid = 1'b1;
      wr_addr  = base_q + CL_ADDR_W'(lines_q) + CL_ADDR_W'(1);
      wr_data  = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      output_permit <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      base_q        <= '0;
      lines_q       <= '0;
      rsp_count     <= '0;
      drain_cnt     <= '0;
      error_q       <= 1'b0;
    end else begin
      state         <= state_nxt;
      output_permit <= permit_nxt;
      if (state != DRAIN) drain_cnt <= '0;
      else if (drain_cnt != 2'd3) drain_cnt <= drain_cnt + 2'd1;
      if (arm) begin
        base_q    <= base_addr;
        lines_q   <= '0;
        rsp_count <= '0;
        error_q   <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) begin
          rd_ptr  <= rd_ptr + PTR_W'(1);
          lines_q <= lines_q + 32'd1;
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
        if (drop) error_q <= 1'b1;
        // Responses count from the first data write on, so early ones are never lost.
        if (wr_rsp_valid && (state != IDLE) && (state != DONE)) rsp_count <= rsp_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= output_data;
  end

endmodule
